fp_div_param: RTL
=================

FP_DIV_PARAM -- requirements
Module: fp_div_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (range 7..52); W = 1+EXP_W+MAN_W.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-004 SHALL have ports: input_a in W, dividend; input_a_stb in 1, dividend valid; input_a_ack out 1, dividend accepted.
REQ-005 SHALL have ports: input_b in W, divisor; input_b_stb in 1, divisor valid; input_b_ack out 1, divisor accepted.
REQ-006 SHALL have port input_rm in 2, rounding mode sampled with input_b: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf).
REQ-007 SHALL have ports: output_z out W, quotient; output_z_flags out 5, {invalid, div_by_zero, overflow, underflow, inexact}; output_z_stb out 1, result valid; output_z_ack in 1, result taken.

Function
REQ-008 SHALL implement FSM GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT, DIVIDE, NORM_1, NORM_2, ROUND, PACK, PUT_Z, in that order; every state except DIVIDE and the normalise loops lasts one cycle.
REQ-009 SHALL, in GET_A/GET_B, raise ack the cycle after entry; transfer occurs on a cycle with ack=1 and stb=1, data is captured, ack drops next cycle, FSM advances.
REQ-010 SHALL, in PUT_Z, assert output_z_stb with output_z and output_z_flags stable until a cycle with stb=1 and ack=1, then deassert stb and return to GET_A.
REQ-011 SHALL hold unbiased exponents in signed EXP_W+2-bit registers; bias = 2^(EXP_W-1)-1.
REQ-012 SHALL handle special cases in SPECIAL, going directly to PUT_Z: NaN operand, inf/inf or 0/0 -> canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0), invalid=1; x/0 with x finite nonzero -> signed inf, div_by_zero=1; inf/finite -> signed inf; finite/inf or 0/nonzero -> signed zero; no other flags.
REQ-013 SHALL normalise subnormal operands (NORM_A, NORM_B), shifting left one bit and decrementing exponent per cycle until hidden bit is 1.
REQ-014 SHALL compute the quotient by restoring radix-2 division, one quotient bit per DIVIDE cycle, exactly MAN_W+4 cycles; sticky = OR of remainder != 0.
REQ-015 SHALL in NORM_1 shift left until mantissa MSB set or exponent reaches emin; in NORM_2 shift right, accumulating sticky, while exponent < emin.
REQ-016 SHALL round per sampled mode: RNE ties-to-even; RTZ truncate; RUP increment if inexact and positive; RDN increment if inexact and negative; mantissa carry-out increments exponent.
REQ-017 SHALL on overflow (exponent > emax after rounding) return inf for RNE, for RUP if positive, for RDN if negative; otherwise max finite of that sign; set overflow=1, inexact=1.
REQ-018 SHALL set inexact when any of guard/round/sticky is nonzero; underflow when result is tiny before rounding and inexact.
REQ-019 SHALL encode subnormal results with exponent field 0 when exponent = emin and hidden bit 0.
REQ-020 SHALL ignore input_a_stb, input_b_stb, output_z_ack in states where they are not examined.

Reset
REQ-021 SHALL, with rst=1 at a clock edge, enter GET_A and force input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z_flags=0, output_z=0, regardless of state; rst dominates any simultaneous handshake.
REQ-022 SHALL abandon any in-flight operation on reset; no result is emitted for it, and the next operation starts clean.

Verification
REQ-023 Default params, RNE: 0x40C00000 / 0x40000000 -> 0x40400000, flags 0; 0x3F800000 / 0x40400000 -> 0x3EAAAAAB, inexact; same with RTZ -> 0x3EAAAAAA.
REQ-024 Default params: 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero; 0x00000000 / 0x00000000 -> 0x7FC00000, invalid; 0x7F800000 / 0x7F800000 -> 0x7FC00000, invalid.
REQ-025 Default params: 0x7F7FFFFF / 0x3F000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, flags overflow|inexact in both.
REQ-026 Default params: 0x00800000 / 0x40000000 -> 0x00400000, flags 0 (exact subnormal); 0x00000001 / 0x40000000 RNE -> 0x00000000, underflow|inexact.
REQ-027 EXP_W=5, MAN_W=10: 0x3C00 / 0x4000 -> 0x3800; 0x7BFF / 0x3800 RNE -> 0x7C00, overflow|inexact.
REQ-028 Assert rst during DIVIDE, then hold output_z_ack=1 with stb held low for 2 cycles -> output_z_stb never rises for the aborted operation; a fresh 0x40C00000/0x40000000 -> 0x40400000; back-pressure (ack held low 10 cycles) keeps output_z stable.

Source files
------------

// File: rtl/fp_div_param.sv
// rtl/fp_div_param.sv - parameterised IEEE-style floating-point divider with stb/ack handshakes
//
// Multi-cycle divider: captures a dividend and a divisor through stb/ack
// handshakes, divides them with a restoring radix-2 loop and returns the
// rounded quotient plus exception flags through an stb/ack output handshake.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   input_a[_stb/_ack]    dividend handshake
//   input_b[_stb/_ack]    divisor handshake (input_rm sampled with it)
//   input_rm              0 RNE, 1 RTZ, 2 RUP, 3 RDN
//   output_z[_stb/_ack]   quotient handshake
//   output_z_flags        {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic                   input_b_stb,
  output logic                   input_b_ack,
  input  logic [1:0]             input_rm,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic [4:0]             output_z_flags,
  output logic                   output_z_stb,
  input  logic                   output_z_ack
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;       // signed unbiased exponent width
  localparam int MW   = MAN_W + 1;       // mantissa including hidden bit
  localparam int QW   = MAN_W + 4;       // quotient: hidden, fraction, guard, round, sticky slot
  localparam int CW   = $clog2(QW);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT,
    DIVIDE, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d, z_q, z_d;
  logic [1:0]             rm_q, rm_d;
  logic                   a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
  logic [4:0]             flags_q, flags_d;
  logic [MW-1:0]          a_m_q, a_m_d, b_m_q, b_m_d, rm_m_q, rm_m_d;
  logic signed [EW-1:0]   a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic                   z_s_q, z_s_d;
  logic [QW-1:0]          q_q, q_d;
  logic [MW:0]            rem_q, rem_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sticky_q, sticky_d, tiny_q, tiny_d, inexact_q, inexact_d;

  logic [MW:0]            rem_n;
  logic [MW:0]            sum;
  logic                   grd, rnd, stk, ix, inc, ovf_inf;
  logic [EXP_W-1:0]       exp_f;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_exp  = a_q[W-2 -: EXP_W];
  assign b_exp  = b_q[W-2 -: EXP_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_frac = b_q[MAN_W-1:0];
  assign a_nan  = (&a_exp) && (|a_frac);
  assign b_nan  = (&b_exp) && (|b_frac);
  assign a_inf  = (&a_exp) && !(|a_frac);
  assign b_inf  = (&b_exp) && !(|b_frac);
  assign a_zero = !(|a_exp) && !(|a_frac);
  assign b_zero = !(|b_exp) && !(|b_frac);

  always_comb begin
    state_d = state_q;  a_d = a_q;  b_d = b_q;  z_d = z_q;  rm_d = rm_q;
    a_ack_d = a_ack_q;  b_ack_d = b_ack_q;  z_stb_d = z_stb_q;  flags_d = flags_q;
    a_m_d = a_m_q;  b_m_d = b_m_q;  rm_m_d = rm_m_q;
    a_e_d = a_e_q;  b_e_d = b_e_q;  z_e_d = z_e_q;  z_s_d = z_s_q;
    q_d = q_q;  rem_d = rem_q;  cnt_d = cnt_q;
    sticky_d = sticky_q;  tiny_d = tiny_q;  inexact_d = inexact_q;
    rem_n = '0;  sum = '0;  grd = 1'b0;  rnd = 1'b0;  stk = 1'b0;
    ix = 1'b0;  inc = 1'b0;  ovf_inf = 1'b0;  exp_f = '0;

    case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d = input_a;  a_ack_d = 1'b0;  state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d = input_b;  rm_d = input_rm;  b_ack_d = 1'b0;  state_d = UNPACK;
        end
      end
      UNPACK: begin
        // A zero exponent field means subnormal: exponent emin, hidden bit 0.
        a_m_d = {|a_exp, a_frac};
        b_m_d = {|b_exp, b_frac};
        a_e_d = (|a_exp) ? ($signed({2'b00, a_exp}) - BIAS_E) : EMIN_E;
        b_e_d = (|b_exp) ? ($signed({2'b00, b_exp}) - BIAS_E) : EMIN_E;
        z_s_d = a_q[W-1] ^ b_q[W-1];
        state_d = SPECIAL;
      end
      SPECIAL: begin
        flags_d = '0;
        state_d = PUT_Z;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
          z_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
          flags_d[4] = 1'b1;
        end else if (a_inf) begin
          z_d = {z_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf || a_zero) begin
          z_d = {z_s_q, {(W-1){1'b0}}};
        end else if (b_zero) begin
          z_d = {z_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d[3] = 1'b1;
        end else begin
          state_d = NORM_A;
        end
      end
      NORM_A: begin
        if (!a_m_q[MW-1]) begin
          a_m_d = {a_m_q[MW-2:0], 1'b0};  a_e_d = a_e_q - EW'(1);
        end else state_d = NORM_B;
      end
      NORM_B: begin
        if (!b_m_q[MW-1]) begin
          b_m_d = {b_m_q[MW-2:0], 1'b0};  b_e_d = b_e_q - EW'(1);
        end else state_d = DIV_INIT;
      end
      DIV_INIT: begin
        // Both mantissas are in [1,2), so the remainder always stays below 2*b.
        rem_d = {1'b0, a_m_q};  q_d = '0;  cnt_d = '0;  sticky_d = 1'b0;
        z_e_d = a_e_q - b_e_q;
        state_d = DIVIDE;
      end
      DIVIDE: begin
        if (rem_q >= {1'b0, b_m_q}) begin
          rem_n = rem_q - {1'b0, b_m_q};  q_d = {q_q[QW-2:0], 1'b1};
        end else begin
          rem_n = rem_q;  q_d = {q_q[QW-2:0], 1'b0};
        end
        rem_d = {rem_n[MW-1:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1)) begin
          sticky_d = |rem_n;
          state_d = NORM_1;
        end
      end
      NORM_1: begin
        if (!q_q[QW-1] && (z_e_q > EMIN_E)) begin
          q_d = {q_q[QW-2:0], 1'b0};  z_e_d = z_e_q - EW'(1);
        end else state_d = NORM_2;
      end
      NORM_2: begin
        if (z_e_q < EMIN_E) begin
          q_d = {1'b0, q_q[QW-1:1]};  sticky_d = sticky_q | q_q[0];  z_e_d = z_e_q + EW'(1);
        end else state_d = ROUND;
      end
      ROUND: begin
        grd = q_q[2];
        rnd = q_q[1];
        stk = q_q[0] | sticky_q;
        ix  = grd | rnd | stk;
        case (rm_q)
          2'd0:    inc = grd & (rnd | stk | q_q[3]);
          2'd1:    inc = 1'b0;
          2'd2:    inc = ix & !z_s_q;
          default: inc = ix & z_s_q;
        endcase
        inexact_d = ix;
        tiny_d    = !q_q[QW-1];
        sum = {1'b0, q_q[QW-1:3]} + (MW+1)'(inc);
        if (sum[MW]) begin
          rm_m_d = sum[MW:1];  z_e_d = z_e_q + EW'(1);
        end else begin
          rm_m_d = sum[MW-1:0];
        end
        state_d = PACK;
      end
      PACK: begin
        if (z_e_q > BIAS_E) begin
          ovf_inf = (rm_q == 2'd0) || ((rm_q == 2'd2) && !z_s_q) || ((rm_q == 2'd3) && z_s_q);
          z_d = ovf_inf ? {z_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                        : {z_s_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          flags_d = 5'b00101;
        end else begin
          // Hidden bit clear here only happens at emin: encode as subnormal.
          exp_f = rm_m_q[MAN_W] ? (z_e_q[EXP_W-1:0] + EXP_W'(BIAS)) : '0;
          z_d = {z_s_q, exp_f, rm_m_q[MAN_W-1:0]};
          flags_d = {3'b000, tiny_q & inexact_q, inexact_q};
        end
        state_d = PUT_Z;
      end
      PUT_Z: begin
        z_stb_d = 1'b1;
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;  state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;  a_q <= '0;  b_q <= '0;  z_q <= '0;  rm_q <= '0;
      a_ack_q <= 1'b0;  b_ack_q <= 1'b0;  z_stb_q <= 1'b0;  flags_q <= '0;
      a_m_q <= '0;  b_m_q <= '0;  rm_m_q <= '0;
      a_e_q <= '0;  b_e_q <= '0;  z_e_q <= '0;  z_s_q <= 1'b0;
      q_q <= '0;  rem_q <= '0;  cnt_q <= '0;
      sticky_q <= 1'b0;  tiny_q <= 1'b0;  inexact_q <= 1'b0;
    end else begin
      state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  z_q <= z_d;  rm_q <= rm_d;
      a_ack_q <= a_ack_d;  b_ack_q <= b_ack_d;  z_stb_q <= z_stb_d;  flags_q <= flags_d;
      a_m_q <= a_m_d;  b_m_q <= b_m_d;  rm_m_q <= rm_m_d;
      a_e_q <= a_e_d;  b_e_q <= b_e_d;  z_e_q <= z_e_d;  z_s_q <= z_s_d;
      q_q <= q_d;  rem_q <= rem_d;  cnt_q <= cnt_d;
      sticky_q <= sticky_d;  tiny_q <= tiny_d;  inexact_q <= inexact_d;
    end
  end

  assign input_a_ack    = a_ack_q;
  assign input_b_ack    = b_ack_q;
  assign output_z       = z_q;
  assign output_z_flags = flags_q;
  assign output_z_stb   = z_stb_q;

endmodule
